keypad_scan: RTL and testbench



---
 rtl/keypad_pkg.sv | 53 +++++
 rtl/keypad_scan_if.sv | 11 +
 rtl/scan_tick.sv | 19 +
 rtl/keypad_scan.sv | 136 +++++++++++++
 tb/tb_keypad_scan.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner: FSM states,
// active-low column patterns, key code layout and debounce limits.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    // Key code as reported on the key output: {row_idx, col_idx}.
    typedef struct packed {
        logic [1:0] row_idx;
        logic [1:0] col_idx;
    } key_code_t;

    localparam int DEBOUNCE_MIN = 2;
    localparam int DEBOUNCE_MAX = 15;

    localparam logic [3:0] COL_IDX3 = 4'b0111;
    localparam logic [3:0] COL_IDX2 = 4'b1011;
    localparam logic [3:0] COL_IDX1 = 4'b1101;
    localparam logic [3:0] COL_IDX0 = 4'b1110;

    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        logic [3:0] pat;
        case (idx)
            2'd3:    pat = COL_IDX3;
            2'd2:    pat = COL_IDX2;
            2'd1:    pat = COL_IDX1;
            default: pat = COL_IDX0;
        endcase
        return pat;
    endfunction

    // True when exactly one active-low row line is asserted.
    function automatic logic single_low(input logic [3:0] rows);
        return (rows == 4'b1110) || (rows == 4'b1101) ||
               (rows == 4'b1011) || (rows == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pins plus the decoded key report; master is the scanner side.
interface keypad_scan_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_down;

    modport master (input row, output col, key, key_valid, key_down);
    modport slave  (output row, input col, key, key_valid, key_down);
endinterface

// File: rtl/scan_tick.sv
// Free-running divider producing a one-cycle tick every 2^SCAN_DIV cycles.
module scan_tick #(
    parameter int SCAN_DIV = 17
) (
    input  logic clk50,
    input  logic rst_n,
    output logic tick
);

    logic [SCAN_DIV-1:0] div;

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) div <= '0;
        else        div <= div + 1'b1;
    end

    assign tick = &div;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad reader: active-low one-hot column scan, debounced press and
// release detection, one key_valid pulse per accepted press.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 17,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic          clk50,
    input  logic          rst_n,
    keypad_scan_if.master kp
);

    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_CNT);

    generate
        if (DEBOUNCE_CNT < DEBOUNCE_MIN || DEBOUNCE_CNT > DEBOUNCE_MAX) begin : g_bad_debounce
            $error("DEBOUNCE_CNT out of range");
        end
    endgenerate

    logic       tick;
    logic [3:0] row_meta, row_sync;
    state_t     state, state_next;
    logic [1:0] col_idx, col_next;
    logic [3:0] cnt, cnt_next, cnt_inc;
    logic [1:0] lat_row, lat_row_next, lat_col, lat_col_next;
    key_code_t  key_r, key_next;
    logic       valid_r, valid_next, down_r, down_next;

    scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk50 (clk50),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Row lines are asynchronous to clk50; idle (pulled-up) value is all ones.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= kp.row;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) state <= SCAN;
        else        state <= state_next;
    end

    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

    always_comb begin
        state_next   = state;
        col_next     = col_idx;
        cnt_next     = cnt;
        lat_row_next = lat_row;
        lat_col_next = lat_col;
        key_next     = key_r;
        valid_next   = 1'b0;
        down_next    = down_r;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (single_low(row_sync)) begin
                        lat_row_next = low_index(row_sync);
                        lat_col_next = col_idx;
                        cnt_next     = 4'd1;
                        state_next   = DEBOUNCE;
                    end else begin
                        col_next = col_idx - 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (single_low(row_sync) && low_index(row_sync) == lat_row) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == DB_LIMIT) begin
                            key_next   = '{row_idx: lat_row, col_idx: lat_col};
                            valid_next = 1'b1;
                            down_next  = 1'b1;
                            cnt_next   = 4'd0;
                            state_next = HELD;
                        end
                    end else begin
                        cnt_next   = 4'd0;
                        col_next   = col_idx - 2'd1;
                        state_next = SCAN;
                    end
                end
                HELD: begin
                    // Any low row restarts the release count; column stays frozen.
                    if (row_sync == 4'b1111) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == DB_LIMIT) begin
                            down_next  = 1'b0;
                            cnt_next   = 4'd0;
                            col_next   = col_idx - 2'd1;
                            state_next = SCAN;
                        end
                    end else begin
                        cnt_next = 4'd0;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            col_idx <= 2'd3;
            cnt     <= 4'd0;
            lat_row <= 2'd0;
            lat_col <= 2'd0;
            key_r   <= '0;
            valid_r <= 1'b0;
            down_r  <= 1'b0;
        end else begin
            col_idx <= col_next;
            cnt     <= cnt_next;
            lat_row <= lat_row_next;
            lat_col <= lat_col_next;
            key_r   <= key_next;
            valid_r <= valid_next;
            down_r  <= down_next;
        end
    end

    assign kp.col       = col_pattern(col_idx);
    assign kp.key       = key_r;
    assign kp.key_valid = valid_r;
    assign kp.key_down  = down_r;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with SCAN_DIV=2, DEBOUNCE_CNT=3; a switch-matrix
// model drives the rows and a queue holds the key codes expected on key_valid.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pressed = '0;
    logic [3:0]  row_drive;

    int          passed = 0;
    int          total  = 0;
    int          phase  = 0;
    bit          last_tick = 1'b0;
    logic [3:0]  exp_q[$];

    keypad_scan_if kif();

    keypad_scan #(.SCAN_DIV(2), .DEBOUNCE_CNT(3)) dut (
        .clk50 (clk),
        .rst_n (rst_n),
        .kp    (kif)
    );

    always #5 clk = ~clk;

    // Switch matrix: a closed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_drive = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kif.col[c]) row_drive[r] = 1'b0;
    end
    assign kif.row = row_drive;

    task automatic step();
        bit t;
        logic [3:0] e;
        t = rst_n && (phase == 3);
        @(posedge clk);
        #1;
        if (rst_n) phase = (phase + 1) % 4;
        last_tick = t;
        if (kif.key_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_key_valid key=%b required no pulse", kif.key);
            end else begin
                e = exp_q.pop_front();
                if (kif.key !== e) $display("FAIL key_on_valid got=%b required=%b", kif.key, e);
                else passed++;
            end
        end
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_tick) return;
        end
        total++;
        $display("FAIL tick_timeout got=none required=tick within 8 cycles");
    endtask

    task automatic wait_col(input logic [3:0] target);
        for (int i = 0; i < 8; i++) begin
            if (kif.col === target) return;
            wait_tick();
        end
        total++;
        $display("FAIL col_timeout got=%b required=%b", kif.col, target);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++; if (kif.col !== 4'b0111) $display("FAIL reset_col got=%b required=0111", kif.col); else passed++;
        total++; if (kif.key !== 4'h0) $display("FAIL reset_key got=%h required=0", kif.key); else passed++;
        total++; if (kif.key_valid !== 1'b0) $display("FAIL reset_valid got=%b required=0", kif.key_valid); else passed++;
        total++; if (kif.key_down !== 1'b0) $display("FAIL reset_down got=%b required=0", kif.key_down); else passed++;
        rst_n = 1'b1;
        phase = 0;
    endtask

    task automatic test_idle_scan();
        logic [3:0] seq [5];
        seq[0] = 4'b1011; seq[1] = 4'b1101; seq[2] = 4'b1110; seq[3] = 4'b0111; seq[4] = 4'b1011;
        repeat (3) step();
        total++; if (kif.col !== 4'b0111) $display("FAIL first_tick_early got=%b required=0111", kif.col); else passed++;
        for (int i = 0; i < 5; i++) begin
            wait_tick();
            total++; if (kif.col !== seq[i]) $display("FAIL idle_col%0d got=%b required=%b", i, kif.col, seq[i]); else passed++;
        end
        total++; if (kif.key !== 4'h0 || kif.key_down !== 1'b0)
            $display("FAIL idle_outputs got=key %h down %b required=key 0 down 0", kif.key, kif.key_down); else passed++;
    endtask

    task automatic test_single_press();
        wait_col(4'b1101);
        pressed = 16'h0020;
        exp_q.push_back(4'b0101);
        wait_tick();
        total++; if (kif.col !== 4'b1101) $display("FAIL press_freeze got=%b required=1101", kif.col); else passed++;
        wait_tick();
        total++; if (kif.key_down !== 1'b0) $display("FAIL press_early_down got=%b required=0", kif.key_down); else passed++;
        wait_tick();
        total++; if (kif.key_down !== 1'b1 || kif.key !== 4'b0101)
            $display("FAIL press_accept got=down %b key %b required=down 1 key 0101", kif.key_down, kif.key); else passed++;
        repeat (7) wait_tick();
        total++; if (kif.col !== 4'b1101 || kif.key_down !== 1'b1)
            $display("FAIL press_hold got=col %b down %b required=col 1101 down 1", kif.col, kif.key_down); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL press_pending got=%0d required=0", exp_q.size()); else passed++;
        pressed = '0;
        repeat (2) wait_tick();
        total++; if (kif.key_down !== 1'b1) $display("FAIL release_early got=%b required=1", kif.key_down); else passed++;
        wait_tick();
        total++; if (kif.key_down !== 1'b0 || kif.col !== 4'b1110)
            $display("FAIL release_done got=down %b col %b required=down 0 col 1110", kif.key_down, kif.col); else passed++;
        total++; if (kif.key !== 4'b0101) $display("FAIL key_retained got=%b required=0101", kif.key); else passed++;
    endtask

    task automatic test_bounce();
        wait_col(4'b0111);
        pressed = 16'h0800;
        repeat (2) wait_tick();
        total++; if (kif.col !== 4'b0111) $display("FAIL bounce_freeze got=%b required=0111", kif.col); else passed++;
        pressed = '0;
        wait_tick();
        total++; if (kif.col !== 4'b1011 || kif.key_down !== 1'b0)
            $display("FAIL bounce_resume got=col %b down %b required=col 1011 down 0", kif.col, kif.key_down); else passed++;
    endtask

    task automatic test_multi_row();
        logic [3:0] seq [4];
        seq[0] = 4'b0111; seq[1] = 4'b1011; seq[2] = 4'b1101; seq[3] = 4'b1110;
        wait_col(4'b1110);
        pressed = 16'h0011;
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            total++; if (kif.col !== seq[i]) $display("FAIL multi_col%0d got=%b required=%b", i, kif.col, seq[i]); else passed++;
        end
        pressed = '0;
        total++; if (kif.key_down !== 1'b0) $display("FAIL multi_down got=%b required=0", kif.key_down); else passed++;
    endtask

    task automatic test_glitch_held();
        wait_col(4'b1011);
        pressed = 16'h4000;
        exp_q.push_back(4'b1110);
        repeat (3) wait_tick();
        total++; if (kif.key_down !== 1'b1 || kif.key !== 4'b1110)
            $display("FAIL glitch_accept got=down %b key %b required=down 1 key 1110", kif.key_down, kif.key); else passed++;
        pressed = '0;
        repeat (2) wait_tick();
        pressed = 16'h4000;
        wait_tick();
        total++; if (kif.key_down !== 1'b1) $display("FAIL glitch_restart got=%b required=1", kif.key_down); else passed++;
        pressed = '0;
        repeat (2) wait_tick();
        total++; if (kif.key_down !== 1'b1) $display("FAIL glitch_early_release got=%b required=1", kif.key_down); else passed++;
        wait_tick();
        total++; if (kif.key_down !== 1'b0 || kif.col !== 4'b1101)
            $display("FAIL glitch_release got=down %b col %b required=down 0 col 1101", kif.key_down, kif.col); else passed++;
    endtask

    task automatic test_reset_held();
        wait_col(4'b0111);
        pressed = 16'h0008;
        exp_q.push_back(4'b0011);
        repeat (3) wait_tick();
        total++; if (kif.key_down !== 1'b1) $display("FAIL rh_accept got=%b required=1", kif.key_down); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (kif.col !== 4'b0111 || kif.key !== 4'h0 || kif.key_valid !== 1'b0 || kif.key_down !== 1'b0)
            $display("FAIL rh_async got=col %b key %h valid %b down %b required=col 0111 key 0 valid 0 down 0",
                     kif.col, kif.key, kif.key_valid, kif.key_down); else passed++;
        repeat (2) step();
        rst_n = 1'b1;
        phase = 0;
        exp_q.push_back(4'b0011);
        repeat (2) wait_tick();
        total++; if (kif.key_down !== 1'b0 || exp_q.size() != 1)
            $display("FAIL rh_early got=down %b pending %0d required=down 0 pending 1", kif.key_down, exp_q.size()); else passed++;
        wait_tick();
        total++; if (kif.key_down !== 1'b1 || kif.key !== 4'b0011 || exp_q.size() != 0)
            $display("FAIL rh_redetect got=down %b key %b pending %0d required=down 1 key 0011 pending 0",
                     kif.key_down, kif.key, exp_q.size()); else passed++;
        pressed = '0;
        repeat (3) wait_tick();
        total++; if (kif.key_down !== 1'b0) $display("FAIL rh_release got=%b required=0", kif.key_down); else passed++;
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_press();
        test_bounce();
        test_multi_row();
        test_glitch_held();
        test_reset_held();
        repeat (8) step();
        total++; if (exp_q.size() != 0) $display("FAIL final_pending got=%0d required=0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
